pht_update_drain_queue: RTL
===========================

// Module: pht_update_drain_queue
// PURPOSE
//  Drain side of the PHT update queue. Resolved branches push PhtQueueEntry {phtWA, phtWV} updates.
//  The block buffers them in a circular FIFO. It retires one per cycle into the PHT write port
//  whenever the PHT write port is not claimed by fetch-side PHT traffic.
//  Sits between branch resolution (IntegerBackEnd BranchResult path) and the PHT RAM write port in FetchUnit.
// PARAMETERS
//  QUEUE_SIZE    32  entries; power of two; pointer width = $clog2(QUEUE_SIZE)
//  ADDR_WIDTH    32  width of phtWA (AddrPath)
//  ENTRY_WIDTH    2  width of phtWV (PHT_EntryPath, saturating counter value)
//  DROP_CNT_WIDTH 16 width of dropped-update counter
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               asynchronous, active-low reset
//  enqValid   in   1               update offered this cycle
//  enqAddr    in   ADDR_WIDTH      PHT write address of update
//  enqValue   in   ENTRY_WIDTH     new counter value
//  portBusy   in   1               PHT write port claimed this cycle; no retire allowed
//  phtWE      out  1               PHT write enable (retire strobe)
//  phtWA      out  ADDR_WIDTH      PHT write address
//  phtWV      out  ENTRY_WIDTH     PHT write value
//  full       out  1               count == QUEUE_SIZE
//  empty      out  1               count == 0
//  count      out  $clog2(QUEUE_SIZE)+1  occupancy
//  dropCount  out  DROP_CNT_WIDTH  saturating count of discarded updates
// BEHAVIOUR
//  Reset (rst_n=0, async, any time incl. mid-drain)
//   - Head/tail pointers and count := 0; dropCount := 0; storage contents don't-care.
//   - Outputs: phtWE=0, phtWA=0, phtWV=0, empty=1, full=0.
//  Enqueue
//   - Condition: enqValid && (!full || retire this cycle).
//   - Writes entry at tail; tail := tail+1, wrapping mod QUEUE_SIZE.
//  Retire
//   - retire = !empty && !portBusy.
//   - phtWE=retire; phtWA/phtWV = head entry (combinational from head); head := head+1, wrapping.
//  Latency
//   - An update enqueued at cycle N appears on phtWE no earlier than cycle N+1.
//  Occupancy
//   - count := count + enq - retire, registered; empty/full derived from count.
//  Full handling
//   - enqValid && full && !retire: the update is dropped and the queue is unchanged.
//   - dropCount increments and saturates at all-ones.
//  Simultaneous events
//   - enq+retire when full: both occur, count stays QUEUE_SIZE.
//   - enq+retire otherwise: count unchanged.
//  Ordering
//   - Strict FIFO; updates to the same address retire in arrival order; no merging.
//  Stall
//   - portBusy held high indefinitely: queue fills to QUEUE_SIZE, then drops; no deadlock.
//  No X on outputs when empty: phtWE=0; phtWA/phtWV may hold the stale head entry.
// CONFIGURATION
//  PHT_UPDATE_BYPASS_EN defined:
//   - Condition: empty && enqValid && !portBusy.
//   - The update goes straight to phtWE/phtWA/phtWV in the same cycle.
//   - It is not stored; count stays 0 (0-cycle latency).
//  PHT_UPDATE_BYPASS_EN undefined:
//   - Every update passes through storage; minimum latency 1 cycle.
// TESTING
//  T1 reset: drive rst_n=0 mid-drain with count=5 -> same cycle phtWE=0, count=0, empty=1; dropCount=0.
//  T2 order: enqueue A=0x100/v1, B=0x104/v2, C=0x100/v3, portBusy=0
//   -> retire A, B, C on consecutive cycles starting next cycle (bypass off).
//  T3 full/drop: portBusy=1, enqueue 34 updates -> count=32, full=1, dropCount=2.
//   - Release portBusy -> 32 retires in order, then empty=1.
//  T4 simultaneous: at full, enqValid=1 with portBusy=0 -> retire head, accept new, count stays 32, dropCount unchanged.
//  T5 wrap: 40 enq/retire pairs at rate 1/cycle -> pointers wrap past 31, values retire in order, no drops.
//  T6 bypass (PHT_UPDATE_BYPASS_EN): empty, enqValid, portBusy=0 -> phtWE=1 same cycle with enq data, count stays 0.
//   - Same stimulus with portBusy=1 -> stored, count=1.

Source files
------------

// File: rtl/pht_update_drain_queue.sv
// pht_update_drain_queue: circular FIFO of PHT updates retired one per cycle into a shared PHT write port.
// Define PHT_UPDATE_BYPASS_EN to let an update offered to an empty, idle queue write the PHT in the same cycle.
module pht_update_drain_queue #(
    parameter int QUEUE_SIZE     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ENTRY_WIDTH    = 2,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enqValid,
    input  logic [ADDR_WIDTH-1:0]        enqAddr,
    input  logic [ENTRY_WIDTH-1:0]       enqValue,
    input  logic                         portBusy,
    output logic                         phtWE,
    output logic [ADDR_WIDTH-1:0]        phtWA,
    output logic [ENTRY_WIDTH-1:0]       phtWV,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(QUEUE_SIZE):0]  count,
    output logic [DROP_CNT_WIDTH-1:0]    dropCount
);
    localparam int PW = $clog2(QUEUE_SIZE);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]     addr_mem [QUEUE_SIZE];
    logic [ENTRY_WIDTH-1:0]    val_mem  [QUEUE_SIZE];
    logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      bypass, retire, enq, drop;

`ifdef PHT_UPDATE_BYPASS_EN
    assign bypass = empty && enqValid && !portBusy;
`else
    assign bypass = 1'b0;
`endif

    assign empty  = count_q == '0;
    assign full   = count_q == CW'(QUEUE_SIZE);
    assign retire = !empty && !portBusy;
    // A retire frees the head slot this cycle, so a full queue can still accept.
    assign enq    = enqValid && !bypass && (!full || retire);
    assign drop   = enqValid && full && !retire;

    always_comb begin
        phtWE   = retire || bypass;
        phtWA   = retire ? addr_mem[head_q] : bypass ? enqAddr : '0;
        phtWV   = retire ? val_mem[head_q] : bypass ? enqValue : '0;
        head_d  = retire ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(enq) - CW'(retire);
        drop_d  = (drop && !(&drop_q)) ? drop_q + DROP_CNT_WIDTH'(1) : drop_q;
    end

    assign count     = count_q;
    assign dropCount = drop_q;

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_q] <= enqAddr;
            val_mem[tail_q]  <= enqValue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end
endmodule
